// File: rtl/pdm_mic_ctrl.sv
// pdm_mic_ctrl: stereo PDM mic clock generator, wake-up sequencer and
// left/right bit demultiplexer for a shared data line.
module pdm_mic_ctrl #(
   parameter int CLK_DIV     = 8,
   parameter int WAKE_CYCLES = 1024,
   parameter int CNT_W       = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic pdm_data,
   output logic pdm_clk,
   output logic left_bit,
   output logic left_valid,
   output logic right_bit,
   output logic right_valid,
   output logic running,
   output logic busy
);
   localparam int HALF = CLK_DIV / 2;
   localparam int DW   = $clog2(CLK_DIV);
   typedef enum logic [1:0] {IDLE, WAKE, RUN, STOP} state_t;
   state_t           state_q;
   logic [DW-1:0]    div_q;
   logic [CNT_W-1:0] wake_q;
   logic             pdm_clk_q, left_bit_q, left_valid_q, right_bit_q, right_valid_q, running_q, busy_q;
   logic             wrap, last_hi;
   logic [DW-1:0]    div_d;
   assign wrap    = div_q == DW'(CLK_DIV - 1);
   assign last_hi = div_q == DW'(HALF - 1);
   assign div_d   = wrap ? '0 : div_q + 1'b1;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         div_q         <= '0;
         wake_q        <= '0;
         pdm_clk_q     <= 1'b0;
         left_bit_q    <= 1'b0;
         left_valid_q  <= 1'b0;
         right_bit_q   <= 1'b0;
         right_valid_q <= 1'b0;
         running_q     <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         left_valid_q  <= 1'b0;
         right_valid_q <= 1'b0;
         if (state_q != IDLE) begin
            div_q     <= div_d;
            pdm_clk_q <= div_d < DW'(HALF);
         end
         case (state_q)
            IDLE: if (en) begin
               state_q   <= WAKE;
               div_q     <= '0;
               pdm_clk_q <= 1'b1;
               busy_q    <= 1'b1;
            end
            WAKE: begin
               if (!en) begin
                  state_q <= STOP;
                  wake_q  <= '0;
               end else if (wrap) begin
                  if (wake_q == CNT_W'(WAKE_CYCLES - 1)) begin
                     state_q   <= RUN;
                     wake_q    <= '0;
                     running_q <= 1'b1;
                  end else begin
                     wake_q <= wake_q + 1'b1;
                  end
               end
            end
            RUN: begin
               // a capture on the edge that leaves RUN is dropped
               if (!en) begin
                  state_q   <= STOP;
                  running_q <= 1'b0;
               end else begin
                  if (last_hi) begin
                     left_bit_q   <= pdm_data;
                     left_valid_q <= 1'b1;
                  end
                  if (wrap) begin
                     right_bit_q   <= pdm_data;
                     right_valid_q <= 1'b1;
                  end
               end
            end
            STOP: if (wrap) begin
               state_q   <= IDLE;
               pdm_clk_q <= 1'b0;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end
   assign pdm_clk     = pdm_clk_q;
   assign left_bit    = left_bit_q;
   assign left_valid  = left_valid_q;
   assign right_bit   = right_bit_q;
   assign right_valid = right_valid_q;
   assign running     = running_q;
   assign busy        = busy_q;
endmodule

// File: tb/tb_pdm_mic_ctrl.sv
// tb_pdm_mic_ctrl: directed scenarios with a strobe scoreboard for pdm_mic_ctrl
// (CLK_DIV=8, WAKE_CYCLES=4).
module tb_pdm_mic_ctrl;
   logic clk = 1'b0, rst = 1'b1, en = 1'b0, inv = 1'b0;
   logic pdm_data, pdm_clk, left_bit, left_valid, right_bit, right_valid, running, busy;
   int cyc = 0, checks = 0, errors = 0;
   int p, p2, p3, p4, p5;
   typedef struct {bit ch; bit val; int t;} exp_t;
   exp_t q[$];
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // mic model: drives the line high during high phases (inverted when inv=1)
   assign pdm_data = pdm_clk ^ inv;
   pdm_mic_ctrl #(.CLK_DIV(8), .WAKE_CYCLES(4), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .en(en), .pdm_data(pdm_data), .pdm_clk(pdm_clk),
      .left_bit(left_bit), .left_valid(left_valid), .right_bit(right_bit),
      .right_valid(right_valid), .running(running), .busy(busy)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at cyc %0d", name, act, exp, cyc);
      end
   endtask
   task automatic push(input bit ch, input bit val, input int t);
      exp_t e;
      e.ch = ch; e.val = val; e.t = t;
      q.push_back(e);
   endtask
   task automatic at(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic sample(input int t);
      at(t);
      @(negedge clk);
   endtask
   always @(negedge clk) begin
      exp_t e;
      if (left_valid && right_valid) chk("both_valid", 1, 0);
      else if (left_valid || right_valid) begin
         if (q.size() == 0) chk("unexpected_strobe_cyc", cyc, 0);
         else begin
            e = q.pop_front();
            chk("strobe_channel", right_valid, e.ch);
            chk("strobe_bit", right_valid ? right_bit : left_bit, e.val);
            chk("strobe_cycle", cyc, e.t);
         end
      end
   end
   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_pdm_clk", pdm_clk, 0);
      chk("rst_left", {left_bit, left_valid}, 0);
      chk("rst_right", {right_bit, right_valid}, 0);
      chk("rst_running", running, 0);
      chk("rst_busy", busy, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      // normal start, stop mid-RUN at div_cnt=2
      en = 1'b1;
      p = cyc + 1;
      for (int j = 0; j < 3; j++) begin
         push(0, 1, p + 36 + 8 * j);
         push(1, 0, p + 40 + 8 * j);
      end
      for (int k = 0; k < 40; k++) begin
         sample(p + k);
         chk("wake_pdm_clk", pdm_clk, (k % 8) < 4);
         chk("wake_running", running, k >= 32);
         chk("wake_busy", busy, 1);
      end
      at(p + 58);
      en = 1'b0;
      sample(p + 59);
      chk("stop_pdm_clk_hi", pdm_clk, 1);
      chk("stop_running", running, 0);
      sample(p + 60);
      chk("stop_pdm_clk_lo", pdm_clk, 0);
      sample(p + 63);
      chk("stop_busy_last", busy, 1);
      sample(p + 64);
      chk("idle_busy", busy, 0);
      chk("idle_pdm_clk", pdm_clk, 0);
      sample(p + 68);
      chk("idle_pdm_clk_hold", pdm_clk, 0);
      // en pulse inside STOP, inverted data
      at(p + 66);
      inv = 1'b1;
      en = 1'b1;
      p2 = cyc + 1;
      push(0, 0, p2 + 36);
      push(1, 1, p2 + 40);
      at(p2 + 42);
      en = 1'b0;
      at(p2 + 44);
      en = 1'b1;
      sample(p2 + 47);
      chk("pulse_busy_stop", busy, 1);
      sample(p2 + 48);
      chk("pulse_busy_idle", busy, 0);
      chk("pulse_pdm_clk_idle", pdm_clk, 0);
      p3 = p2 + 49;
      push(0, 0, p3 + 36);
      push(1, 1, p3 + 40);
      push(0, 0, p3 + 44);
      sample(p3);
      chk("rewake_pdm_clk", pdm_clk, 1);
      chk("rewake_busy", busy, 1);
      sample(p3 + 31);
      chk("rewake_running_lo", running, 0);
      sample(p3 + 32);
      chk("rewake_running_hi", running, 1);
      // reset in RUN at div_cnt=5
      at(p3 + 45);
      rst = 1'b1;
      at(p3 + 46);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_pdm_clk", pdm_clk, 0);
      chk("mid_rst_valids", {left_valid, right_valid}, 0);
      chk("mid_rst_running", running, 0);
      chk("mid_rst_busy", busy, 0);
      p4 = p3 + 47;
      push(0, 0, p4 + 36);
      sample(p4 + 31);
      chk("postrst_running_lo", running, 0);
      sample(p4 + 32);
      chk("postrst_running_hi", running, 1);
      at(p4 + 37);
      en = 1'b0;
      sample(p4 + 40);
      chk("postrst_idle_busy", busy, 0);
      // abort during WAKE after two periods
      at(p4 + 44);
      en = 1'b1;
      p5 = cyc + 1;
      at(p5 + 16);
      en = 1'b0;
      sample(p5 + 17);
      chk("abort_running", running, 0);
      sample(p5 + 23);
      chk("abort_busy_stop", busy, 1);
      sample(p5 + 24);
      chk("abort_busy_idle", busy, 0);
      chk("abort_pdm_clk", pdm_clk, 0);
      at(p5 + 80);
      chk("pending_strobes", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
